mem_port_arbiter: RTL and testbench

//  Shares the single memory port between instruction fetch (I-port) and the MEM stage (D-port).

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: rw_flag opcodes, owner ids, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // rw_flag protocol shared by both requesters and the memory controller
    localparam logic [1:0] RW_NONE  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;

    // Which requester owns the outstanding memory transaction
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    // Arbiter FSM states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the MEM stage (D); D has priority, I gets anti-starvation.
// Latency: chosen request reaches memory combinationally (0 cycles); completion routed back in the mem_done cycle.
// Backpressure: x_busy is raised for any live request not issued this cycle; mem_busy stalls all issue.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  i_rw_flag,
    input  logic [31:0] i_addr,
    output logic        i_busy,
    output logic        i_done,
    output logic [31:0] i_read_data,
    input  logic [1:0]  d_rw_flag,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_write_data,
    input  logic [3:0]  d_write_mask,
    output logic        d_busy,
    output logic        d_done,
    output logic [31:0] d_read_data,
    output logic [1:0]  rw_flag,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic [3:0]  write_mask,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [31:0] read_data
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic             state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic i_req, d_req, can_issue, issue_i, issue_d;

    // Fetch can only read; any other encoding counts as idle.
    assign i_req = (i_rw_flag == RW_READ);
    assign d_req = (d_rw_flag != RW_NONE);

    // Pick a winner and drive the memory request straight through; everything is quiet while in reset.
    always_comb begin
        can_issue  = 1'b0;
        issue_i    = 1'b0;
        issue_d    = 1'b0;
        rw_flag    = RW_NONE;
        addr       = 32'd0;
        write_data = 32'd0;
        write_mask = 4'd0;
        if (!RST) begin
            can_issue = !mem_busy && ((state_q == ST_IDLE) || (state_q == ST_WAIT && mem_done));
            if (can_issue) begin
                if (starve_cnt_q < LIMIT_C) begin
                    issue_d = d_req;
                    issue_i = !d_req && i_req;
                end else begin
                    issue_i = i_req;
                    issue_d = !i_req && d_req;
                end
            end
            if (issue_d) begin
                rw_flag    = d_rw_flag;
                addr       = d_addr;
                write_data = d_write_data;
                write_mask = d_write_mask;
            end else if (issue_i) begin
                rw_flag = RW_READ;
                addr    = i_addr;
            end
        end
    end

    // Busy/done/read-data back to the requesters; a done with no owner is silently dropped.
    always_comb begin
        i_busy      = 1'b0;
        d_busy      = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        i_read_data = 32'd0;
        d_read_data = 32'd0;
        if (!RST) begin
            i_busy = i_req && !issue_i;
            d_busy = d_req && !issue_d;
            i_done = mem_done && (owner_q == OWN_I);
            d_done = mem_done && (owner_q == OWN_D);
            if (i_done) i_read_data = read_data;
            if (d_done) d_read_data = read_data;
        end
    end

    // Next state, owner and starvation count.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        if (issue_i || issue_d) begin
            state_d = ST_WAIT;
            owner_d = issue_i ? OWN_I : OWN_D;
        end else if (state_q == ST_WAIT && mem_done) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
        end
        if (!i_req || issue_i) begin
            starve_cnt_d = '0;
        end else if (issue_d && starve_cnt_q < LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // State registers; reset abandons any outstanding transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, back-to-back handoff, starvation, reset and idle encodings.
// Latency: inputs change on the falling edge, outputs are checked 1 ns later, state moves on the rising edge.
// Backpressure: mem_busy and mem_done are driven directly from the stimulus.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  i_rw_flag;
    logic [31:0] i_addr;
    logic        i_busy, i_done;
    logic [31:0] i_read_data;
    logic [1:0]  d_rw_flag;
    logic [31:0] d_addr, d_write_data;
    logic [3:0]  d_write_mask;
    logic        d_busy, d_done;
    logic [31:0] d_read_data;
    logic [1:0]  rw_flag;
    logic [31:0] addr, write_data;
    logic [3:0]  write_mask;
    logic        mem_busy, mem_done;
    logic [31:0] read_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_busy(i_busy), .i_done(i_done), .i_read_data(i_read_data),
        .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_write_data(d_write_data), .d_write_mask(d_write_mask),
        .d_busy(d_busy), .d_done(d_done), .d_read_data(d_read_data),
        .rw_flag(rw_flag), .addr(addr), .write_data(write_data), .write_mask(write_mask),
        .mem_busy(mem_busy), .mem_done(mem_done), .read_data(read_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to the next low phase and let combinational outputs settle after inputs change there.
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        i_rw_flag = 2'd0; i_addr = 32'd0;
        d_rw_flag = 2'd0; d_addr = 32'd0; d_write_data = 32'd0; d_write_mask = 4'd0;
        mem_busy = 1'b0; mem_done = 1'b0; read_data = 32'd0;
        #2;
        chk("rst_rw_flag", 32'(rw_flag), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
        next_cycle();
        RST = 1'b0;

        // 1: D read on idle bus, completes two cycles later
        next_cycle();
        d_rw_flag = 2'd1; d_addr = 32'h100;
        #1;
        chk("t1_rw_flag", 32'(rw_flag), 32'd1);
        chk("t1_addr", addr, 32'h100);
        chk("t1_d_busy", 32'(d_busy), 32'd0);
        next_cycle();
        d_rw_flag = 2'd0;
        #1;
        chk("t1_wait_rw", 32'(rw_flag), 32'd0);
        chk("t1_wait_done", 32'(d_done), 32'd0);
        next_cycle();
        mem_done = 1'b1; read_data = 32'hDEADBEEF;
        #1;
        chk("t1_d_done", 32'(d_done), 32'd1);
        chk("t1_d_rdata", d_read_data, 32'hDEADBEEF);
        chk("t1_i_done", 32'(i_done), 32'd0);
        chk("t1_i_rdata", i_read_data, 32'd0);
        next_cycle();
        mem_done = 1'b0; read_data = 32'd0;
        #1;
        chk("t1_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // 2: simultaneous I read and D write; I handed off in D's done cycle
        next_cycle();
        i_rw_flag = 2'd1; i_addr = 32'h0;
        d_rw_flag = 2'd2; d_addr = 32'h200; d_write_data = 32'h12; d_write_mask = 4'b0001;
        #1;
        chk("t2_rw_flag", 32'(rw_flag), 32'd2);
        chk("t2_addr", addr, 32'h200);
        chk("t2_wdata", write_data, 32'h12);
        chk("t2_wmask", 32'(write_mask), 32'h1);
        chk("t2_i_busy", 32'(i_busy), 32'd1);
        chk("t2_d_busy", 32'(d_busy), 32'd0);
        next_cycle();
        d_rw_flag = 2'd0;
        #1;
        chk("t2_wait_i_busy", 32'(i_busy), 32'd1);
        chk("t2_wait_rw", 32'(rw_flag), 32'd0);
        next_cycle();
        mem_done = 1'b1; read_data = 32'h5555AAAA;
        #1;
        chk("t2_d_done", 32'(d_done), 32'd1);
        chk("t2_b2b_rw", 32'(rw_flag), 32'd1);
        chk("t2_b2b_addr", addr, 32'h0);
        chk("t2_b2b_wmask", 32'(write_mask), 32'd0);
        chk("t2_b2b_wdata", write_data, 32'd0);
        chk("t2_b2b_i_busy", 32'(i_busy), 32'd0);
        next_cycle();
        mem_done = 1'b0; i_rw_flag = 2'd0;
        next_cycle();
        mem_done = 1'b1; read_data = 32'hCAFEF00D;
        #1;
        chk("t2_i_done", 32'(i_done), 32'd1);
        chk("t2_i_rdata", i_read_data, 32'hCAFEF00D);
        chk("t2_d_done_lo", 32'(d_done), 32'd0);
        next_cycle();
        mem_done = 1'b0; read_data = 32'd0;

        // 3: D requests continuously while I waits; I wins the 5th issue
        next_cycle();
        i_rw_flag = 2'd1; i_addr = 32'h40;
        d_rw_flag = 2'd1; d_addr = 32'h300;
        #1;
        chk("t3_issue1_addr", addr, 32'h300);
        chk("t3_issue1_i_busy", 32'(i_busy), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            next_cycle();
            mem_done = 1'b1;
            #1;
            if (k < 5) begin
                chk($sformatf("t3_issue%0d_addr", k), addr, 32'h300);
                chk($sformatf("t3_issue%0d_cnt", k), 32'(dut.starve_cnt_q), 32'(k - 1));
            end else begin
                chk("t3_issue5_cnt", 32'(dut.starve_cnt_q), 32'd4);
                chk("t3_issue5_addr", addr, 32'h40);
                chk("t3_issue5_i_busy", 32'(i_busy), 32'd0);
                chk("t3_issue5_d_busy", 32'(d_busy), 32'd1);
            end
        end
        next_cycle();
        mem_done = 1'b0; i_rw_flag = 2'd0; d_rw_flag = 2'd0;
        #1;
        chk("t3_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        next_cycle();
        mem_done = 1'b1;
        #1;
        chk("t3_i_done", 32'(i_done), 32'd1);
        next_cycle();
        mem_done = 1'b0;

        // 4: memory busy stalls both; D first once it clears
        next_cycle();
        mem_busy = 1'b1; i_rw_flag = 2'd1; d_rw_flag = 2'd1;
        #1;
        chk("t4_rw_flag", 32'(rw_flag), 32'd0);
        chk("t4_i_busy", 32'(i_busy), 32'd1);
        chk("t4_d_busy", 32'(d_busy), 32'd1);
        next_cycle();
        mem_busy = 1'b0;
        #1;
        chk("t4_rw_flag_go", 32'(rw_flag), 32'd1);
        chk("t4_addr_d", addr, 32'h300);
        chk("t4_d_busy_go", 32'(d_busy), 32'd0);
        next_cycle();
        d_rw_flag = 2'd0;
        #1;
        chk("t4_wait", 32'(dut.state_q), 32'(ST_WAIT));

        // 5: reset mid-WAIT, then a stale mem_done
        RST = 1'b1;
        #1;
        chk("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t5_rw_flag", 32'(rw_flag), 32'd0);
        chk("t5_addr", addr, 32'd0);
        chk("t5_i_busy", 32'(i_busy), 32'd0);
        next_cycle();
        RST = 1'b0; i_rw_flag = 2'd0;
        mem_done = 1'b1; read_data = 32'h77777777;
        #1;
        chk("t5_i_done", 32'(i_done), 32'd0);
        chk("t5_d_done", 32'(d_done), 32'd0);
        chk("t5_d_rdata", d_read_data, 32'd0);
        next_cycle();
        mem_done = 1'b0; read_data = 32'd0;
        #1;
        chk("t5_state_after", 32'(dut.state_q), 32'(ST_IDLE));

        // 6: I-port encoding 2 is idle
        next_cycle();
        i_rw_flag = 2'd2; i_addr = 32'h80;
        #1;
        chk("t6_i_busy", 32'(i_busy), 32'd0);
        chk("t6_rw_flag", 32'(rw_flag), 32'd0);
        next_cycle();
        #1;
        chk("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
        i_rw_flag = 2'd0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
